// File: rtl/mem_dbus_ctrl.sv
// mem_dbus_ctrl: OpenMIPS memory stage driving a req/ack data bus, with LL/SC LLbit and pipeline stall.
module mem_dbus_ctrl (
  input  logic        clk,
  input  logic        Rst_n,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic        whilo_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        flush_i,
  input  logic        wb_stall_i,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_sel_o,
  output logic [31:0] dbus_wdata_o,
  input  logic        dbus_ack_i,
  input  logic [31:0] dbus_rdata_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o,
  output logic        align_err_o,
  output logic        llbit_o
);
  localparam logic [7:0] LB = 8'hE0, LBU = 8'hE4, LH = 8'hE1, LHU = 8'hE5, LW = 8'hE3;
  localparam logic [7:0] SB = 8'hE8, SH = 8'hE9, SW = 8'hEB, LL = 8'hF0, SC = 8'hF8;
  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
  state_t state, state_nx;
  logic flush_pend, llbit, req_q, we_q;
  logic [31:0] addr_q, wdata_q, rdata_q, bw_nx, load_res;
  logic [3:0] sel_q, sel_nx;
  logic [7:0] rbyte;
  logic [15:0] rhalf;
  logic is_byte, is_half, is_word, is_store, is_mem, misalign, start;
  always_comb begin
    is_byte  = aluop_i inside {LB, LBU, SB};
    is_half  = aluop_i inside {LH, LHU, SH};
    is_word  = aluop_i inside {LW, SW, LL, SC};
    is_store = aluop_i inside {SB, SH, SW, SC};
    is_mem   = is_byte | is_half | is_word;
    misalign = (is_half & mem_addr_i[0]) | (is_word & |mem_addr_i[1:0]);
    // a failing SC completes in place without touching the bus
    start    = is_mem & ~misalign & ~(aluop_i == SC & ~llbit);
    sel_nx   = is_byte ? 4'b1000 >> mem_addr_i[1:0] : is_half ? (mem_addr_i[1] ? 4'b0011 : 4'b1100) : 4'b1111;
    bw_nx    = is_byte ? {4{reg2_i[7:0]}} : is_half ? {2{reg2_i[15:0]}} : reg2_i;
    rbyte    = rdata_q[{~mem_addr_i[1:0], 3'b000} +: 8];
    rhalf    = rdata_q[{~mem_addr_i[1], 4'b0000} +: 16];
    load_res = aluop_i == LB  ? {{24{rbyte[7]}}, rbyte} :
               aluop_i == LBU ? {24'b0, rbyte} :
               aluop_i == LH  ? {{16{rhalf[15]}}, rhalf} :
               aluop_i == LHU ? {16'b0, rhalf} : rdata_q;
  end
  always_ff @(posedge clk or negedge Rst_n)
    if (!Rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE ? (!flush_i && start ? BUS : IDLE) :
               state == BUS  ? (!dbus_ack_i ? BUS : (flush_i || flush_pend) ? IDLE : DONE) :
               (!flush_i && wb_stall_i ? DONE : IDLE);
  end
  always_ff @(posedge clk or negedge Rst_n)
    if (!Rst_n) begin
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      sel_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      llbit      <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      if (state == IDLE && state_nx == BUS) begin
        req_q   <= 1'b1;
        we_q    <= is_store;
        addr_q  <= {mem_addr_i[31:2], 2'b00};
        sel_q   <= sel_nx;
        wdata_q <= bw_nx;
      end
      if (state == BUS && dbus_ack_i) begin
        req_q   <= 1'b0;
        rdata_q <= dbus_rdata_i;
      end
      // a flush seen while waiting for ack must still discard the result once ack arrives
      flush_pend <= state == BUS && !dbus_ack_i && (flush_pend || flush_i);
      llbit      <= flush_i ? 1'b0 :
                    state == DONE && aluop_i == LL ? 1'b1 :
                    state == DONE && aluop_i == SC ? 1'b0 : llbit;
    end
  always_comb begin
    dbus_req_o   = req_q;
    dbus_we_o    = we_q;
    dbus_addr_o  = addr_q;
    dbus_sel_o   = sel_q;
    dbus_wdata_o = wdata_q;
    llbit_o      = llbit;
    stallreq_o   = Rst_n && ((state == IDLE && start) || state == BUS);
    align_err_o  = Rst_n && misalign;
    wd_o         = Rst_n ? wd_i : '0;
    whilo_o      = Rst_n && whilo_i;
    hi_o         = Rst_n ? hi_i : '0;
    lo_o         = Rst_n ? lo_i : '0;
    wreg_o       = Rst_n && !misalign && (aluop_i == SC || wreg_i);
    // SC reaching DONE always succeeded; llbit is already cleared while DONE is held
    wdata_o      = !Rst_n ? '0 :
                   aluop_i == SC ? {31'b0, llbit || state == DONE} :
                   is_mem && !is_store ? load_res : wdata_i;
  end
endmodule

// File: tb/tb_mem_dbus_ctrl.sv
// tb_mem_dbus_ctrl: vector table, flush/reset sequences and randomized ops against a spec-level model.
module tb_mem_dbus_ctrl;
  localparam logic [7:0] LB = 8'hE0, LBU = 8'hE4, LH = 8'hE1, LHU = 8'hE5, LW = 8'hE3;
  localparam logic [7:0] SB = 8'hE8, SH = 8'hE9, SW = 8'hEB, LL = 8'hF0, SC = 8'hF8;
  localparam logic [7:0] NOP = 8'h00, ADD = 8'h20;

  logic clk, Rst_n, wreg_i, whilo_i, flush_i, wb_stall_i, dbus_ack_i;
  logic [4:0] wd_i, wd_o;
  logic [7:0] aluop_i;
  logic [31:0] wdata_i, mem_addr_i, reg2_i, hi_i, lo_i, dbus_rdata_i;
  logic dbus_req_o, dbus_we_o, wreg_o, whilo_o, stallreq_o, align_err_o, llbit_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o, wdata_o, hi_o, lo_o;
  logic [3:0] dbus_sel_o;

  mem_dbus_ctrl dut (
    .clk(clk), .Rst_n(Rst_n), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .aluop_i(aluop_i),
    .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .whilo_i(whilo_i), .hi_i(hi_i), .lo_i(lo_i),
    .flush_i(flush_i), .wb_stall_i(wb_stall_i), .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o),
    .dbus_addr_o(dbus_addr_o), .dbus_sel_o(dbus_sel_o), .dbus_wdata_o(dbus_wdata_o),
    .dbus_ack_i(dbus_ack_i), .dbus_rdata_i(dbus_rdata_i), .wd_o(wd_o), .wreg_o(wreg_o),
    .wdata_o(wdata_o), .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o),
    .align_err_o(align_err_o), .llbit_o(llbit_o)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct {
    logic bus; logic we; logic [3:0] sel; logic [31:0] baddr, bwdata, res; logic wreg, align;
  } exp_t;
  typedef struct {
    logic [7:0] op; logic [31:0] a, r2, rd, wdi; logic wri; int waits; exp_t e; logic ll;
  } vec_t;
  typedef struct {
    int stalls, reqc; logic [3:0] sel; logic we; logic [31:0] baddr, bwdata, res;
    logic wreg, align, ll, unstable, hold_bad, timeout;
  } obs_t;

  int total = 0, bad = 0;
  logic m_ll;
  vec_t tbl[15];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Expected behaviour from the byte-lane and LL/SC rules, using plain arithmetic.
  function automatic exp_t model(input logic [7:0] op, input logic [31:0] a, r2, rd, wdi,
                                 input logic wri, input logic llb);
    exp_t e;
    int sz, idx;
    logic [31:0] v;
    logic sgn, st;
    e = '{bus: 0, we: 0, sel: 0, baddr: 0, bwdata: 0, res: 0, wreg: 0, align: 0};
    sz = (op == LB || op == LBU || op == SB) ? 1 : (op == LH || op == LHU || op == SH) ? 2 :
         (op == LW || op == SW || op == LL || op == SC) ? 4 : 0;
    st = (op == SB || op == SH || op == SW || op == SC);
    sgn = (op == LB || op == LH);
    idx = int'(a % 4);
    if (sz == 0) begin
      e.res = wdi; e.wreg = wri; return e;
    end
    if (a % sz != 0) begin
      e.align = 1; return e;
    end
    if (op == SC && !llb) begin
      e.wreg = 1; return e;
    end
    e.bus = 1; e.we = st; e.baddr = a - (a % 4); e.wreg = (op == SC) ? 1'b1 : wri;
    e.res = st ? wdi : rd;
    if (sz == 4) begin
      e.sel = 4'hF; e.bwdata = r2;
    end else if (sz == 2) begin
      e.sel = 4'(3 << (2 * (1 - idx / 2)));
      e.bwdata = (r2 % 65536) * 32'h00010001;
      v = (rd >> (16 * (1 - idx / 2))) % 65536;
      if (!st) e.res = (sgn && v >= 32768) ? v + 32'hFFFF0000 : v;
    end else begin
      e.sel = 4'(1 << (3 - idx));
      e.bwdata = (r2 % 256) * 32'h01010101;
      v = (rd >> (8 * (3 - idx))) % 256;
      if (!st) e.res = (sgn && v >= 128) ? v + 32'hFFFFFF00 : v;
    end
    if (op == SC) e.res = 1;
    return e;
  endfunction

  // Drive one op, act as a slave acking after `waits` cycles, optionally hold MEM/WB in DONE.
  task automatic run_op(input logic [7:0] op, input logic [31:0] a, r2, rd, wdi, input logic wri,
                        input int waits, input int hold, output obs_t o);
    int wc;
    bit done;
    o = '{stalls: 0, reqc: 0, sel: 0, we: 0, baddr: 0, bwdata: 0, res: 0, wreg: 0, align: 0,
          ll: 0, unstable: 0, hold_bad: 0, timeout: 0};
    aluop_i = op; mem_addr_i = a; reg2_i = r2; wdata_i = wdi; wreg_i = wri;
    wc = 0; done = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!stallreq_o) begin
        o.res = wdata_o; o.wreg = wreg_o; o.align = align_err_o; done = 1;
        break;
      end
      o.stalls++;
      if (dbus_req_o) begin
        if (o.reqc > 0 && (o.sel !== dbus_sel_o || o.we !== dbus_we_o || o.baddr !== dbus_addr_o ||
                           o.bwdata !== dbus_wdata_o)) o.unstable = 1;
        o.reqc++; o.sel = dbus_sel_o; o.we = dbus_we_o; o.baddr = dbus_addr_o; o.bwdata = dbus_wdata_o;
        if (wc == waits) begin dbus_ack_i = 1; dbus_rdata_i = rd; end
        wc++;
      end
      @(negedge clk);
      dbus_ack_i = 0;
    end
    o.timeout = !done;
    if (hold > 0) begin
      wb_stall_i = 1;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk); #1;
        if (h == hold - 1) wb_stall_i = 0;
        if (stallreq_o || wdata_o !== o.res) o.hold_bad = 1;
      end
    end
    @(posedge clk); #1;
    o.ll = llbit_o;
    aluop_i = NOP;
    @(negedge clk);
  endtask

  task automatic check_all(input string tag, input exp_t e, input int waits, input logic ll, input obs_t o);
    chk($sformatf("%s.timeout", tag), o.timeout, 0);
    chk($sformatf("%s.stall", tag), o.stalls, e.bus ? 2 + waits : 0);
    chk($sformatf("%s.reqc", tag), o.reqc, e.bus ? waits + 1 : 0);
    if (e.bus) begin
      chk($sformatf("%s.sel", tag), o.sel, e.sel);
      chk($sformatf("%s.we", tag), o.we, e.we);
      chk($sformatf("%s.addr", tag), o.baddr, e.baddr);
      chk($sformatf("%s.stable", tag), o.unstable, 0);
    end
    if (e.bus && e.we) chk($sformatf("%s.bwdata", tag), o.bwdata, e.bwdata);
    if (!e.align) chk($sformatf("%s.res", tag), o.res, e.res);
    chk($sformatf("%s.wreg", tag), o.wreg, e.wreg);
    chk($sformatf("%s.align", tag), o.align, e.align);
    chk($sformatf("%s.llbit", tag), o.ll, ll);
    chk($sformatf("%s.hold", tag), o.hold_bad, 0);
  endtask

  initial begin
    obs_t o;
    exp_t e;
    logic [7:0] ops[11];
    logic [31:0] a;
    int w;
    ops = '{LB, LBU, LH, LHU, LW, SB, SH, SW, LL, SC, ADD};
    tbl[0]  = '{LB,  32'h101, 0, 32'h12F45678, 0, 1, 0, '{1, 0, 4'b0100, 32'h100, 0, 32'hFFFFFFF4, 1, 0}, 0};
    tbl[1]  = '{LBU, 32'h101, 0, 32'h12F45678, 0, 1, 0, '{1, 0, 4'b0100, 32'h100, 0, 32'h000000F4, 1, 0}, 0};
    tbl[2]  = '{SH,  32'h202, 32'hAAAA1234, 0, 0, 0, 0, '{1, 1, 4'b0011, 32'h200, 32'h12341234, 0, 0, 0}, 0};
    tbl[3]  = '{LW,  32'h300, 0, 32'hDEADBEEF, 0, 1, 3, '{1, 0, 4'b1111, 32'h300, 0, 32'hDEADBEEF, 1, 0}, 0};
    tbl[4]  = '{LL,  32'h400, 0, 32'h00000055, 0, 1, 0, '{1, 0, 4'b1111, 32'h400, 0, 32'h55, 1, 0}, 1};
    tbl[5]  = '{SC,  32'h400, 32'h77, 0, 0, 0, 0, '{1, 1, 4'b1111, 32'h400, 32'h77, 1, 1, 0}, 0};
    tbl[6]  = '{SC,  32'h400, 32'h77, 0, 0, 0, 0, '{0, 0, 0, 0, 0, 0, 1, 0}, 0};
    tbl[7]  = '{LW,  32'h302, 0, 0, 0, 1, 0, '{0, 0, 0, 0, 0, 0, 0, 1}, 0};
    tbl[8]  = '{LH,  32'h102, 0, 32'h12348001, 0, 1, 1, '{1, 0, 4'b0011, 32'h100, 0, 32'hFFFF8001, 1, 0}, 0};
    tbl[9]  = '{LHU, 32'h100, 0, 32'h9ABC0000, 0, 1, 0, '{1, 0, 4'b1100, 32'h100, 0, 32'h00009ABC, 1, 0}, 0};
    tbl[10] = '{SB,  32'h503, 32'h1122335A, 0, 0, 0, 0, '{1, 1, 4'b0001, 32'h500, 32'h5A5A5A5A, 0, 0, 0}, 0};
    tbl[11] = '{LH,  32'h101, 0, 0, 0, 1, 0, '{0, 0, 0, 0, 0, 0, 0, 1}, 0};
    tbl[12] = '{ADD, 32'h123, 0, 0, 32'hCAFEF00D, 1, 0, '{0, 0, 0, 0, 0, 32'hCAFEF00D, 1, 0}, 0};
    tbl[13] = '{SW,  32'h7FC, 32'h01020304, 0, 0, 0, 2, '{1, 1, 4'b1111, 32'h7FC, 32'h01020304, 0, 0, 0}, 0};
    tbl[14] = '{LB,  32'h103, 0, 32'hFFFFFF7F, 0, 1, 0, '{1, 0, 4'b0001, 32'h100, 0, 32'h0000007F, 1, 0}, 0};

    Rst_n = 0; aluop_i = LW; mem_addr_i = 32'h302; wdata_i = 32'hFFFFFFFF; wreg_i = 1; wd_i = 5'h1F;
    reg2_i = 0; hi_i = 32'h11112222; lo_i = 32'h33334444; whilo_i = 1; flush_i = 0; wb_stall_i = 0;
    dbus_ack_i = 0; dbus_rdata_i = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.stall", stallreq_o, 0);
    chk("rst.req", dbus_req_o, 0);
    chk("rst.wdata", wdata_o, 0);
    chk("rst.wreg", wreg_o, 0);
    chk("rst.align", align_err_o, 0);
    chk("rst.wd", wd_o, 0);
    chk("rst.ll", llbit_o, 0);
    Rst_n = 1; aluop_i = ADD;
    #1;
    chk("pass.wd", wd_o, 5'h1F);
    chk("pass.hi", hi_o, 32'h11112222);
    chk("pass.lo", lo_o, 32'h33334444);
    chk("pass.whilo", whilo_o, 1);
    aluop_i = NOP;
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].r2, tbl[i].rd, tbl[i].wdi, tbl[i].wri, tbl[i].waits,
             (i == 0 || i == 5) ? 2 : 0, o);
      check_all($sformatf("vec%0d", i), tbl[i].e, tbl[i].waits, tbl[i].ll, o);
    end

    // flush while a request is outstanding: result discarded, FSM lands in IDLE
    run_op(LL, 32'h400, 0, 32'h1, 0, 1, 0, 0, o);
    chk("fl.ll_set", o.ll, 1);
    aluop_i = LW; mem_addr_i = 32'h300;
    @(negedge clk); #1;
    chk("fl.req", dbus_req_o, 1);
    flush_i = 1;
    @(negedge clk);
    flush_i = 0; aluop_i = NOP;
    #1;
    chk("fl.ll_clr", llbit_o, 0);
    chk("fl.held", dbus_req_o, 1);
    chk("fl.stall_bus", stallreq_o, 1);
    dbus_ack_i = 1; dbus_rdata_i = 32'hBAD0BAD0;
    @(negedge clk);
    dbus_ack_i = 0;
    #1;
    chk("fl.stall_drop", stallreq_o, 0);
    chk("fl.req_drop", dbus_req_o, 0);
    run_op(LB, 32'h101, 0, 32'h12F45678, 0, 1, 0, 0, o);
    chk("fl.next_stall", o.stalls, 2);
    chk("fl.next_res", o.res, 32'hFFFFFFF4);

    // asynchronous reset in the middle of a bus transaction
    run_op(LL, 32'h400, 0, 32'h1, 0, 1, 0, 0, o);
    aluop_i = LW; mem_addr_i = 32'h300;
    @(negedge clk); #1;
    chk("ar.req", dbus_req_o, 1);
    #1 Rst_n = 0;
    #1;
    chk("ar.req0", dbus_req_o, 0);
    chk("ar.stall0", stallreq_o, 0);
    chk("ar.sel0", dbus_sel_o, 0);
    chk("ar.ll0", llbit_o, 0);
    chk("ar.wreg0", wreg_o, 0);
    aluop_i = NOP;
    @(negedge clk);
    Rst_n = 1;
    @(negedge clk);
    m_ll = 0;

    for (int i = 0; i < 60; i++) begin
      logic [7:0] op;
      logic [31:0] r2, rd, wdi;
      logic wri;
      op = ops[$urandom_range(0, 10)];
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[0] = 1'b0;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      r2 = $urandom; rd = $urandom; wdi = $urandom; wri = 1'($urandom_range(0, 1));
      w = $urandom_range(0, 3);
      e = model(op, a, r2, rd, wdi, wri, m_ll);
      if (e.bus && op == LL) m_ll = 1;
      if (e.bus && op == SC) m_ll = 0;
      run_op(op, a, r2, rd, wdi, wri, w, $urandom_range(0, 2), o);
      check_all($sformatf("rnd%0d", i), e, w, m_ll, o);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_dbus_ctrl.md
# mem_dbus_ctrl

Memory-access stage of the OpenMIPS pipeline: it consumes the EX/MEM pipeline register outputs and performs loads, stores and LL/SC through a request/acknowledge data bus. It holds the pipeline via `stallreq_o` until the bus acknowledges. It also owns the LLbit register. Results go to the MEM/WB register.

## Interface
Parameters: none. Op codes are the `define.v` macros (`EXE_LB_OP`, `EXE_LBU_OP`, `EXE_LH_OP`, `EXE_LHU_OP`, `EXE_LW_OP`, `EXE_SB_OP`, `EXE_SH_OP`, `EXE_SW_OP`, `EXE_LL_OP`, `EXE_SC_OP`).

Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  clock, rising edge
- `Rst_n`  in  1  asynchronous, active-low reset

EX/MEM side:
- `wd_i`  in  5  destination register
- `wreg_i`  in  1  register write enable
- `wdata_i`  in  32  ALU result
- `aluop_i`  in  8  operation
- `mem_addr_i`  in  32  effective address
- `reg2_i`  in  32  store data
- `whilo_i`  in  1  HI/LO write enable
- `hi_i`  in  32  HI value
- `lo_i`  in  32  LO value

Control:
- `flush_i`  in  1  pipeline flush (exception)
- `wb_stall_i`  in  1  `stall[4]`; MEM/WB is holding

Data bus:
- `dbus_req_o`  out  1  request
- `dbus_we_o`  out  1  write
- `dbus_addr_o`  out  32  word address, bits [1:0] = 0
- `dbus_sel_o`  out  4  byte lanes
- `dbus_wdata_o`  out  32  write data
- `dbus_ack_i`  in  1  acknowledge
- `dbus_rdata_i`  in  32  read data

Outputs to MEM/WB:
- `wd_o`  out  5  destination register
- `wreg_o`  out  1  register write enable
- `wdata_o`  out  32  result
- `whilo_o`  out  1  HI/LO write enable
- `hi_o`  out  32  HI value
- `lo_o`  out  32  LO value

Status:
- `stallreq_o`  out  1  stall request to the controller
- `align_err_o`  out  1  misaligned access
- `llbit_o`  out  1  current LLbit

## Operation
- Non-memory ops:
  - All `*_i` values pass straight to `*_o`.
  - No bus activity; `stallreq_o` = 0.
- Memory op = any of the ten op codes above. A failing SC (LLbit = 0) is not a bus access.
- Misalignment:
  - Halfword ops with `mem_addr_i[0]` = 1 are misaligned; word ops, LL and SC with `mem_addr_i[1:0]` ≠ 0 are misaligned.
  - On misalignment: `align_err_o` = 1, `wreg_o` = 0, no bus access, no stall.
- Byte lanes are big-endian:
  - Byte: address offset 0 → sel 1000, rdata[31:24]; offset 3 → sel 0001, rdata[7:0].
  - Halfword: addr[1] = 0 → sel 1100; addr[1] = 1 → sel 0011.
  - Word: sel 1111.
- Store data: SB drives `{4{reg2_i[7:0]}}`, SH drives `{2{reg2_i[15:0]}}`, SW and SC drive `reg2_i`.
- Load results:
  - LB and LH sign-extend; LBU and LHU zero-extend.
  - LW and LL return the full word.
  - Stores drive `wreg_o` = `wreg_i`. SC drives `wreg_o` = 1 and `wdata_o` = 1 on success, 0 on failure.
- LLbit:
  - Set to 1 when an LL completes (DONE).
  - Cleared when an SC completes successfully.
  - Cleared by `flush_i`.
- FSM states: IDLE, BUS, DONE.
  - IDLE, valid memory op:
    - `stallreq_o` = 1 (combinational).
    - At the next edge, register addr/sel/wdata/we, set `dbus_req_o` = 1, go to BUS.
  - BUS:
    - `stallreq_o` = 1; `dbus_req_o` and the bus fields are held stable.
    - On `dbus_ack_i`: latch `dbus_rdata_i`, clear `dbus_req_o`, go to DONE.
  - DONE:
    - `stallreq_o` = 0; result comes from the latched data.
    - Go to IDLE unless `wb_stall_i` = 1, in which case stay in DONE.
- `flush_i` (flush wins over all other transitions):
  - In IDLE or DONE: next state IDLE.
  - In BUS: the request is held until ack, then the FSM goes to IDLE, not DONE. The result is discarded and `stallreq_o` drops at that transition.
- Reset (asynchronous, any state, including mid-transaction):
  - State IDLE.
  - `dbus_req_o`, `dbus_we_o`, `dbus_addr_o`, `dbus_sel_o`, `dbus_wdata_o`, LLbit and the read latch all 0.
  - While `Rst_n` = 0, every output is 0.

## Timing
- Non-memory op and failing SC: 0 extra cycles.
- Load or store with a zero-wait slave: 3 cycles in the stage (IDLE detect, BUS with ack, DONE). Each slave wait cycle adds 1.
- The `dbus_*` outputs are registered; `stallreq_o` and the result outputs are combinational.
- Inputs are held stable by EX/MEM during the stall. A new op is sampled in the IDLE cycle after DONE.
- Ack outside BUS is ignored.

## Test plan
- LB from addr 0x101 with rdata 0x12F45678 → sel 0100, `wdata_o` = 0xFFFFFFF4. LBU from the same address → 0x000000F4. In both, `stallreq_o` is high for exactly 2 cycles.
- SH of reg2 0xAAAA1234 to addr 0x202 → `dbus_we_o` = 1, sel 0011, wdata 0x12341234, addr 0x200.
- LW to 0x300 with ack delayed 3 cycles → `dbus_req_o` is stable for 4 cycles and `stallreq_o` is high for 5 cycles.
- LL 0x400, then SC 0x400 → SC store issued, `wdata_o` = 1, LLbit 0. A second SC → no bus request, `wdata_o` = 0, no stall.
- LW to 0x302 → `align_err_o` = 1, `wreg_o` = 0, `dbus_req_o` never asserted.
- `flush_i` in BUS: FSM goes to IDLE after ack and LLbit is 0. `Rst_n` low in BUS: `dbus_req_o` = 0 immediately (asynchronous).
